// File: rtl/dac_sample_scheduler_if.sv
// Bundle of control, config, sample and DAC-side signals for the DAC sample scheduler.
interface dac_sample_scheduler_if #(
  parameter int N = 8,
  parameter int W = 16
);
  logic         ena;
  logic         start;
  logic         stop;
  logic         cfg_valid;
  logic [N-1:0] cfg_ticks;
  logic         cfg_ready;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         clr_underrun;
  logic [W-1:0] dac_data;
  logic         dac_load;
  logic         busy;
  logic         underrun;
  logic [7:0]   underrun_cnt;

  modport master (
    output ena, start, stop, cfg_valid, cfg_ticks, s_valid, s_data, clr_underrun,
    input  cfg_ready, s_ready, dac_data, dac_load, busy, underrun, underrun_cnt
  );

  modport slave (
    input  ena, start, stop, cfg_valid, cfg_ticks, s_valid, s_data, clr_underrun,
    output cfg_ready, s_ready, dac_data, dac_load, busy, underrun, underrun_cnt
  );
endinterface

// File: rtl/dac_sample_scheduler.sv
// Paces samples from a 2-entry FIFO into the DAC every period_active+1 enabled cycles.
// States: IDLE (counter parked, no ticks) | RUN (periodic ticks) | STOPPING (one last tick, then IDLE).
module dac_sample_scheduler #(
  parameter int N = 8,
  parameter int W = 16
) (
  input logic                   clk,
  input logic                   rst,
  dac_sample_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t       state;
  logic [N-1:0] counter;
  logic [N-1:0] period_active;
  logic [N-1:0] period_pend;
  logic         pend;
  logic [W-1:0] fifo_q [2];
  logic [1:0]   fifo_cnt;
  logic [W-1:0] dac_data_q;
  logic         dac_load_q;
  logic         underrun_q;
  logic [7:0]   underrun_cnt_q;

  logic tick;
  logic push;
  logic pop;
  logic cfg_take;
  logic empty_tick;

  assign tick       = (state != IDLE) && bus.ena && (counter == period_active);
  assign push       = bus.s_valid && bus.s_ready;
  assign pop        = tick && (fifo_cnt != 2'd0);
  assign empty_tick = tick && (fifo_cnt == 2'd0);
  assign cfg_take   = bus.cfg_valid && bus.cfg_ready;

  assign bus.s_ready      = (fifo_cnt < 2'd2);
  assign bus.cfg_ready    = ~pend;
  assign bus.busy         = (state != IDLE);
  assign bus.dac_data     = dac_data_q;
  assign bus.dac_load     = dac_load_q;
  assign bus.underrun     = underrun_q;
  assign bus.underrun_cnt = underrun_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      counter        <= '0;
      period_active  <= '1;
      period_pend    <= '0;
      pend           <= 1'b0;
      dac_data_q     <= '0;
      dac_load_q     <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      dac_load_q <= tick;
      if (pop) dac_data_q <= fifo_q[0];

      case (state)
        IDLE:     if (bus.start) state <= RUN;
        RUN:      if (bus.stop) state <= STOPPING;
        STOPPING: if (tick) state <= IDLE;
        default:  state <= IDLE;
      endcase

      if ((state != IDLE) && bus.ena) counter <= tick ? '0 : counter + N'(1);

      // Busy-time configs wait for a period boundary so a period is never cut short.
      if (cfg_take && (state == IDLE)) begin
        period_active <= bus.cfg_ticks;
      end else if (tick && pend) begin
        period_active <= period_pend;
        pend          <= 1'b0;
      end
      if (cfg_take && (state != IDLE)) begin
        period_pend <= bus.cfg_ticks;
        pend        <= 1'b1;
      end

      if (empty_tick) begin
        underrun_q <= 1'b1;
        if (bus.clr_underrun) underrun_cnt_q <= 8'd1;
        else if (underrun_cnt_q != 8'hFF) underrun_cnt_q <= underrun_cnt_q + 8'd1;
      end else if (bus.clr_underrun) begin
        underrun_q     <= 1'b0;
        underrun_cnt_q <= '0;
      end
    end
  end

  // No bypass: a sample pushed into an empty FIFO is only visible from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt  <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          fifo_q[fifo_cnt[0]] <= bus.s_data;
          fifo_cnt            <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_q[0] <= fifo_q[1];
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11:   fifo_q[0] <= bus.s_data;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: linear stimulus, hand-computed expectations.
module tb_dac_sample_scheduler;
  localparam logic [15:0] A = 16'hA1A1, B = 16'hB2B2, C = 16'hC3C3, D = 16'hD4D4;
  localparam logic [15:0] E = 16'hE5E5, F = 16'hF6F6, G = 16'h0707;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_fail = 0;

  dac_sample_scheduler_if #(.N(8), .W(16)) bus ();
  dac_sample_scheduler #(.N(8), .W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.ena = 0; bus.start = 0; bus.stop = 0; bus.cfg_valid = 0; bus.cfg_ticks = '0;
    bus.s_valid = 0; bus.s_data = '0; bus.clr_underrun = 0;
    step(); step();
    check("rst_busy", bus.busy, 0);
    check("rst_dac_data", bus.dac_data, 0);
    check("rst_dac_load", bus.dac_load, 0);
    check("rst_underrun", bus.underrun, 0);
    check("rst_cnt", bus.underrun_cnt, 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_s_ready", bus.s_ready, 1);
    rst = 1'b0;

    bus.cfg_valid = 1; bus.cfg_ticks = 8'd3; bus.s_valid = 1; bus.s_data = A;
    step();
    check("idle_cfg_ready", bus.cfg_ready, 1);
    bus.cfg_valid = 0; bus.s_data = B;
    step();
    check("fifo_full_idle", bus.s_ready, 0);
    bus.s_valid = 0; bus.start = 1; bus.ena = 1;
    step();
    check("run_busy", bus.busy, 1);
    bus.start = 0;
    step(); step(); step();
    check("no_early_tick", bus.dac_load, 0);
    step();
    check("tick1_load", bus.dac_load, 1);
    check("tick1_data", bus.dac_data, A);
    check("tick1_s_ready", bus.s_ready, 1);
    step(); step(); step();
    check("between_ticks", bus.dac_load, 0);
    step();
    check("tick2_load", bus.dac_load, 1);
    check("tick2_data", bus.dac_data, B);
    step(); step(); step(); step();
    check("under_load", bus.dac_load, 1);
    check("under_data_held", bus.dac_data, B);
    check("under_flag", bus.underrun, 1);
    check("under_cnt1", bus.underrun_cnt, 1);

    bus.cfg_valid = 1; bus.cfg_ticks = 8'd1;
    step();
    check("pend_cfg_ready0", bus.cfg_ready, 0);
    bus.cfg_valid = 0;
    step();
    check("pend_cfg_ready0b", bus.cfg_ready, 0);
    step(); step();
    check("pend_tick_load", bus.dac_load, 1);
    check("pend_cfg_ready1", bus.cfg_ready, 1);
    check("under_cnt2", bus.underrun_cnt, 2);
    step();
    check("p1_gap", bus.dac_load, 0);
    step();
    check("p1_tick", bus.dac_load, 1);
    check("under_cnt3", bus.underrun_cnt, 3);
    bus.clr_underrun = 1;
    step();
    check("clr_flag", bus.underrun, 0);
    check("clr_cnt", bus.underrun_cnt, 0);
    bus.clr_underrun = 0;
    step();
    check("after_clr_cnt", bus.underrun_cnt, 1);
    step();
    bus.clr_underrun = 1;
    step();
    check("clr_tick_flag", bus.underrun, 1);
    check("clr_tick_cnt", bus.underrun_cnt, 1);
    bus.clr_underrun = 0;

    for (int i = 0; i < 8; i++) begin
      bus.ena = (i % 2 == 1);
      step();
      check("ena_toggle", bus.dac_load, (i % 4 == 3));
    end

    bus.ena = 1; bus.s_valid = 1; bus.s_data = C;
    step();
    bus.s_data = D;
    step();
    check("pushpop_load", bus.dac_load, 1);
    check("pushpop_data", bus.dac_data, C);
    bus.stop = 1; bus.s_data = E;
    step();
    check("stopping_busy", bus.busy, 1);
    check("third_push_blocked", bus.s_ready, 0);
    bus.stop = 0; bus.s_data = F;
    step();
    check("final_tick_load", bus.dac_load, 1);
    check("final_tick_data", bus.dac_data, D);
    check("final_busy_low", bus.busy, 0);
    check("final_s_ready", bus.s_ready, 1);
    step();
    check("no_extra_tick", bus.dac_load, 0);
    check("refill_full", bus.s_ready, 0);
    check("idle_after_stop", bus.busy, 0);

    bus.s_valid = 0; bus.start = 1; bus.stop = 1;
    step();
    check("start_wins", bus.busy, 1);
    bus.start = 0; bus.stop = 0;
    step(); step();
    check("restart_load", bus.dac_load, 1);
    check("restart_data", bus.dac_data, E);
    bus.s_valid = 1; bus.s_data = G; bus.cfg_valid = 1; bus.cfg_ticks = 8'd5;
    step();
    check("pre_rst_cfg_ready", bus.cfg_ready, 0);
    check("pre_rst_s_ready", bus.s_ready, 0);
    bus.s_valid = 0; bus.cfg_valid = 0; rst = 1;
    step();
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_s_ready", bus.s_ready, 1);
    check("mid_rst_cfg_ready", bus.cfg_ready, 1);
    check("mid_rst_data", bus.dac_data, 0);
    check("mid_rst_cnt", bus.underrun_cnt, 0);
    check("mid_rst_load", bus.dac_load, 0);

    rst = 0; bus.start = 1;
    step();
    bus.start = 0;
    repeat (255) step();
    check("default_period_gap", bus.dac_load, 0);
    step();
    check("default_period_tick", bus.dac_load, 1);
    check("fifo_discarded", bus.underrun_cnt, 1);
    check("fifo_discarded_data", bus.dac_data, 0);

    bus.cfg_valid = 1; bus.cfg_ticks = 8'd0; bus.stop = 1;
    step();
    check("stop_pend_cfg", bus.cfg_ready, 0);
    bus.cfg_valid = 0; bus.stop = 0;
    repeat (254) step();
    check("stopping_long", bus.busy, 1);
    step();
    check("stop_final_load", bus.dac_load, 1);
    check("stop_final_idle", bus.busy, 0);
    check("stop_cfg_applied", bus.cfg_ready, 1);
    check("stop_final_cnt", bus.underrun_cnt, 2);

    bus.start = 1;
    step();
    bus.start = 0;
    repeat (260) step();
    check("sat_cnt", bus.underrun_cnt, 255);
    check("sat_flag", bus.underrun, 1);
    check("p0_every_cycle", bus.dac_load, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
